// File: rtl/rle_encoder.sv
`default_nettype none
// rle_encoder: collapses runs of identical symbols into (value, length) tokens with
// valid/ready on both sides, saturating run length and end-of-stream flush. Rev 1.0
module rle_encoder #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [CNT_W-1:0] MAX_RUN = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   run_data, run_data_n;
  logic [CNT_W-1:0]    run_cnt, run_cnt_n;
  logic [DATA_W-1:0]   out_data_n;
  logic [CNT_W-1:0]    out_count_n;
  logic                out_last_n;
  logic                out_valid_n;
  logic                slot_free;
  logic                accept;
  logic                extend;

  // The output slot can take a new token when empty or being drained this cycle.
  assign slot_free = ~out_valid | out_ready;
  assign in_ready  = (state != FLUSH) & slot_free;
  assign accept    = in_valid & in_ready;
  assign extend    = (in_data == run_data) && (run_cnt != MAX_RUN);

  always_comb begin
    state_n     = state;
    run_data_n  = run_data;
    run_cnt_n   = run_cnt;
    out_data_n  = out_data;
    out_count_n = out_count;
    out_last_n  = out_last;
    out_valid_n = out_valid & ~out_ready;

    case (state)
      IDLE: begin
        if (accept) begin
          run_data_n = in_data;
          run_cnt_n  = ONE;
          state_n    = in_last ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (extend) begin
            run_cnt_n = run_cnt + ONE;
          end else begin
            // Breaking beat: close the old run into the slot, open a new one.
            out_data_n  = run_data;
            out_count_n = run_cnt;
            out_last_n  = 1'b0;
            out_valid_n = 1'b1;
            run_data_n  = in_data;
            run_cnt_n   = ONE;
          end
          state_n = in_last ? FLUSH : RUN;
        end
      end
      FLUSH: begin
        if (slot_free) begin
          out_data_n  = run_data;
          out_count_n = run_cnt;
          out_last_n  = 1'b1;
          out_valid_n = 1'b1;
          run_cnt_n   = '0;
          state_n     = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      run_data  <= '0;
      run_cnt   <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      run_data  <= run_data_n;
      run_cnt   <= run_cnt_n;
      out_data  <= out_data_n;
      out_count <= out_count_n;
      out_last  <= out_last_n;
      out_valid <= out_valid_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rle_encoder.sv
`default_nettype none
// tb_rle_encoder: directed vector table, hand sequences and random streams
// checked against a run-splitting reference model.
module tb_rle_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic [2:0] out_count;
  logic       out_last;
  logic       out_valid;
  logic       out_ready = 1'b0;

  rle_encoder #(.DATA_W(8), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_count(out_count), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic [2:0] c; logic l; } tok_t;
  typedef struct packed { logic [7:0] d; logic l; } beat_t;
  typedef struct {
    beat_t [15:0] beats;
    int           nb;
    tok_t  [4:0]  toks;
    int           ne;
    int           mode;
  } vec_t;

  localparam int NV = 7;
  vec_t  vec [NV];
  beat_t src_q [$];
  tok_t  got_q [$];
  tok_t  exp_q [$];
  int    total = 0;
  int    bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic add_beat(input int c, input logic [7:0] d, input logic l);
    vec[c].beats[vec[c].nb] = {d, l};
    vec[c].nb++;
  endtask

  task automatic add_tok(input int c, input logic [7:0] d, input logic [2:0] n, input logic l);
    vec[c].toks[vec[c].ne] = {d, n, l};
    vec[c].ne++;
  endtask

  // Reference: split the beat list into maximal equal runs, then chop each run into chunks of at most 7.
  task automatic build_expected(input beat_t b [$]);
    int i, j, len, c;
    exp_q.delete();
    i = 0;
    while (i < b.size()) begin
      j = i;
      while (j < b.size() && b[j].d == b[i].d) j++;
      len = j - i;
      while (len > 0) begin
        c = (len > 7) ? 7 : len;
        len -= c;
        exp_q.push_back({b[i].d, 3'(c), (j == b.size() && len == 0)});
      end
      i = j;
    end
  endtask

  // Called and returns at posedge+1. mode: 0 ready always, 1 ready 1-in-3, 2 random.
  task automatic run_stream(input int mode, input bit vrand, input bit need_last);
    bit   seen_last = 0;
    bit   held_v = 0;
    tok_t held = '0;
    int   cyc = 0;
    while (!(src_q.size() == 0 && (seen_last || !need_last))) begin
      if (cyc >= 3000) begin
        check("stream_timeout", 32'(cyc), 32'd3000 - 1);
        break;
      end
      in_valid  = (src_q.size() != 0) && (!vrand || ($urandom % 4 != 0));
      in_data   = (src_q.size() != 0) ? src_q[0].d : 8'h00;
      in_last   = (src_q.size() != 0) ? src_q[0].l : 1'b0;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : ($urandom % 3 != 0);
      @(negedge clk);
      if (held_v)
        check("stall_hold", {out_valid, out_data, out_count, out_last}, {1'b1, held});
      held_v = out_valid & ~out_ready;
      held   = {out_data, out_count, out_last};
      if (in_valid && in_ready) void'(src_q.pop_front());
      if (out_valid && out_ready) begin
        got_q.push_back({out_data, out_count, out_last});
        if (out_last) seen_last = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic compare_tokens(input string name);
    int n;
    check({name, "_ntok"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({name, "_tok"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    beat_t rb [$];
    int    sum;
    int    n;
    int    alpha;

    for (int c = 0; c < NV; c++) begin
      vec[c].nb = 0; vec[c].ne = 0; vec[c].mode = 0;
      vec[c].beats = '0; vec[c].toks = '0;
    end
    // 0: mixed runs; 1: same stream with 1-in-3 sink stalls
    for (int c = 0; c < 2; c++) begin
      add_beat(c, 99, 0); add_beat(c, 99, 0); add_beat(c, 97, 0); add_beat(c, 97, 0);
      add_beat(c, 97, 0); add_beat(c, 98, 0); add_beat(c, 100, 0); add_beat(c, 100, 0);
      add_beat(c, 99, 1);
      add_tok(c, 99, 2, 0); add_tok(c, 97, 3, 0); add_tok(c, 98, 1, 0);
      add_tok(c, 100, 2, 0); add_tok(c, 99, 1, 1);
      vec[c].mode = c;
    end
    for (int i = 0; i < 10; i++) add_beat(2, 8'h55, i == 9);
    add_tok(2, 8'h55, 7, 0); add_tok(2, 8'h55, 3, 1);
    for (int i = 0; i < 7; i++) add_beat(3, 8'h55, i == 6);
    add_tok(3, 8'h55, 7, 1);
    for (int i = 0; i < 14; i++) add_beat(4, 8'h3c, i == 13);
    add_tok(4, 8'h3c, 7, 0); add_tok(4, 8'h3c, 7, 1);
    add_beat(5, 3, 0); add_beat(5, 3, 0); add_beat(5, 4, 1);
    add_tok(5, 3, 2, 0); add_tok(5, 4, 1, 1);
    for (int i = 0; i < 8; i++) add_beat(6, 8'hf0, i == 7);
    add_tok(6, 8'hf0, 7, 0); add_tok(6, 8'hf0, 1, 1);
    vec[6].mode = 1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", {out_valid, out_data, out_count, out_last}, 13'h0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    for (int c = 0; c < NV; c++) begin
      got_q.delete(); exp_q.delete(); src_q.delete();
      for (int i = 0; i < vec[c].nb; i++) src_q.push_back(vec[c].beats[i]);
      for (int i = 0; i < vec[c].ne; i++) exp_q.push_back(vec[c].toks[i]);
      run_stream(vec[c].mode, 0, 1);
      compare_tokens($sformatf("vec%0d", c));
    end

    // single beat with last from IDLE
    in_data = 8'ha5; in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    check("flush_no_tok_yet", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("single_tok", {out_valid, out_data, out_count, out_last}, {1'b1, 8'ha5, 3'd1, 1'b1});
    @(posedge clk); #1;
    check("single_drained", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // async reset mid-run, then a fresh stream
    src_q.delete(); got_q.delete();
    src_q.push_back({8'd99, 1'b0}); src_q.push_back({8'd99, 1'b0}); src_q.push_back({8'd97, 1'b0});
    run_stream(0, 0, 0);
    rst = 1'b1;
    #1;
    check("midrst_out", {out_valid, out_data, out_count, out_last}, 13'h0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    got_q.delete(); exp_q.delete();
    src_q.push_back({8'd4, 1'b0}); src_q.push_back({8'd4, 1'b1});
    exp_q.push_back({8'd4, 3'd2, 1'b1});
    run_stream(0, 0, 1);
    compare_tokens("post_reset");

    // random streams against the reference model
    for (int s = 0; s < 24; s++) begin
      n = $urandom_range(1, 30);
      alpha = (s % 2 == 0) ? 3 : 256;
      rb.delete(); src_q.delete(); got_q.delete();
      for (int i = 0; i < n; i++) begin
        rb.push_back({8'($urandom % alpha), i == n - 1});
        src_q.push_back(rb[i]);
      end
      build_expected(rb);
      run_stream(2, 1, 1);
      compare_tokens($sformatf("rand%0d", s));
      sum = 0;
      foreach (got_q[i]) sum += int'(got_q[i].c);
      check("rand_sum", 32'(sum), 32'(n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
